ifu_prefetch: RTL
=================

Name: ifu_prefetch

Overview:
- Instruction-fetch front end, directly upstream of the IF/ID pipeline register.
- Generates the PC and issues pipelined requests on the instruction bus.
- Buffers returned words in a small FIFO and presents {inst, inst_addr, valid} to the IF/ID register.
- Honours the same hold and jump/flush signals as the pipeline registers, so the fetch stream stays coherent with stalls and branches.

Parameters:
- AW, 32, address width.
- DW, 32, instruction width.
- DEPTH, 2, FIFO entries; also the cap on in-flight plus buffered requests (power of 2, ≥2).
- RESET_ADDR, 32'h0000_0000, PC after reset.
- NOP, 32'h0000_0013, instruction driven when no valid instruction is available (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- jump_en_i  in  1  redirect request from EX (branch/jump taken)
- jump_addr_i  in  AW  redirect target
- hold_flag_i  in  1  downstream stall; IF/ID will not accept this cycle
- ibus_req_o  out  1  bus request valid
- ibus_addr_o  out  AW  bus request address
- ibus_gnt_i  in  1  request accepted this cycle (req && gnt = handshake)
- ibus_rvalid_i  in  1  read data valid (in-order, ≥1 cycle after gnt)
- ibus_rdata_i  in  DW  read data
- inst_o  out  DW  instruction to IF/ID
- inst_addr_o  out  AW  address of inst_o
- inst_valid_o  out  1  inst_o/inst_addr_o hold a real instruction

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_ADDR; FIFO empty; outstanding=0; discard=0.
  - Outputs after reset: ibus_req_o=0, ibus_addr_o=RESET_ADDR, inst_valid_o=0, inst_o=NOP, inst_addr_o=RESET_ADDR.
  - Reset mid-operation drops all state; the bus slave shares rst.
- Request issue:
  - ibus_req_o=1 when (fifo_count + outstanding) < DEPTH and jump_en_i==0.
  - ibus_addr_o=pc.
  - On req&&gnt: pc<=pc+4, outstanding+1.
  - req/addr must stay stable until gnt, unless a jump occurs.
- Response:
  - On rvalid: outstanding-1.
  - If discard>0: discard-1 and the data is dropped.
  - Else push {rdata, addr} into the FIFO. Address comes from a companion address queue written at grant.
- Output:
  - inst_valid_o = !empty.
  - inst_o/inst_addr_o = FIFO head when valid; else inst_o=NOP, inst_addr_o=last head addr.
  - Pop when inst_valid_o && !hold_flag_i.
  - Latency: rvalid at cycle N → inst_valid_o at N+1 (registered FIFO, no bypass).
- Push and pop in the same cycle: count unchanged, allowed even when full. Overflow cannot occur because of the issue cap.
- Jump (jump_en_i=1):
  - pc<=jump_addr_i with bits [1:0] forced to 0.
  - FIFO flushed.
  - discard<=outstanding (+1 if a grant occurs this cycle, −1 if rvalid consumes one this cycle).
  - No new request this cycle; first new request next cycle.
  - inst_valid_o=0 next cycle.
- Jump with hold in the same cycle: jump wins; flush still happens.
- Jump while discard>0: discard accumulates per the same formula.
- Hold with FIFO full: requests stop; no data loss.
- PC wraps modulo 2^AW (32'hFFFF_FFFC+4 → 0).

Decomposition:
- Shared package `ifu_pkg`: AW/DW defaults, NOP constant, RESET_ADDR default.
- Sub-module `ifu_fifo`: sync FIFO, width DW+AW, DEPTH entries, push/pop/flush, full/empty/count, reset active-low synchronous.
- PC, outstanding/discard counters and issue logic stay in `ifu_prefetch`.

Test Plan:
- Reset then always-gnt, 1-cycle rvalid, no hold:
  - addresses 0,4,8,… issued back-to-back.
  - inst_valid_o first high 2 cycles after first grant.
  - inst_addr_o increments by 4 each cycle.
- hold_flag_i=1 for 5 cycles with DEPTH=2:
  - at most 2 entries buffered; ibus_req_o drops to 0.
  - inst_o/inst_addr_o stay constant.
  - on release, the stream resumes without a gap or duplicate.
- Jump to 32'h0000_0103 while 2 responses are outstanding:
  - both responses dropped.
  - next ibus_addr_o=32'h0000_0100.
  - first inst_addr_o after the jump = 32'h100.
  - inst_o=NOP while invalid.
- Jump and hold asserted together with a full FIFO:
  - FIFO empty next cycle.
  - request to the jump target on the following cycle.
- gnt stalled 3 cycles:
  - ibus_addr_o held at 32'h8 throughout.
  - single grant, single FIFO entry with addr 32'h8.
- rst driven low mid-stream with 1 response outstanding:
  - next cycle all outputs at reset values.
  - refetch starts from RESET_ADDR.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared defaults for the instruction-fetch front end.
package ifu_pkg;
  localparam int          IFU_AW         = 32;
  localparam int          IFU_DW         = 32;
  localparam logic [31:0] IFU_RESET_ADDR = 32'h0000_0000;
  // addi x0,x0,0
  localparam logic [31:0] IFU_NOP        = 32'h0000_0013;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; registered storage, head read straight from the array.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int W     = IFU_AW + IFU_DW,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    do_push = push_i && (!full_o || do_pop);
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata_i;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: PC generation, pipelined bus requests, response buffering
// and jump/hold coherence with the IF/ID register.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int            AW         = IFU_AW,
  parameter int            DW         = IFU_DW,
  parameter int            DEPTH      = 2,
  parameter logic [AW-1:0] RESET_ADDR = AW'(IFU_RESET_ADDR),
  parameter logic [DW-1:0] NOP        = DW'(IFU_NOP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_en_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          hold_flag_i,
  output logic          ibus_req_o,
  output logic [AW-1:0] ibus_addr_o,
  input  logic          ibus_gnt_i,
  input  logic          ibus_rvalid_i,
  input  logic [DW-1:0] ibus_rdata_i,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o,
  output logic          inst_valid_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] inst;
    logic [AW-1:0] addr;
  } entry_t;

  logic [AW-1:0] pc_q, pc_d, last_q, last_d;
  logic [CW-1:0] disc_q, disc_d;
  logic          en_q, en_d;
  logic [CW-1:0] fifo_cnt, aq_cnt;
  logic          fifo_full, fifo_empty, aq_full, aq_empty;
  entry_t        fifo_wdata, fifo_head;
  logic [AW-1:0] aq_head;
  logic          req, fire, rsp, fifo_push, fifo_pop;

  always_comb begin
    // buffered + in-flight never exceeds DEPTH, so responses always find room
    req       = en_q && !jump_en_i && !aq_full &&
                (({1'b0, fifo_cnt} + {1'b0, aq_cnt}) < (CW+1)'(DEPTH));
    fire      = req && ibus_gnt_i;
    rsp       = ibus_rvalid_i && !aq_empty;
    fifo_pop  = !fifo_empty && !hold_flag_i;
    fifo_push = rsp && (disc_q == '0) && (!fifo_full || fifo_pop);
    fifo_wdata.inst = ibus_rdata_i;
    fifo_wdata.addr = aq_head;

    en_d   = 1'b1;
    pc_d   = pc_q;
    disc_d = disc_q;
    last_d = fifo_empty ? last_q : fifo_head.addr;
    if (fire) pc_d = pc_q + AW'(4);
    if (rsp && (disc_q != '0)) disc_d = disc_q - CW'(1);
    if (jump_en_i) begin
      pc_d   = jump_addr_i & ~AW'(3);
      // everything still in flight after this cycle belongs to the old stream
      disc_d = aq_cnt + CW'(fire) - CW'(rsp);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q   <= 1'b0;
      pc_q   <= RESET_ADDR;
      disc_q <= '0;
      last_q <= RESET_ADDR;
    end else begin
      en_q   <= en_d;
      pc_q   <= pc_d;
      disc_q <= disc_d;
      last_q <= last_d;
    end
  end

  // instruction buffer
  ifu_fifo #(.W(DW + AW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (jump_en_i),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // addresses of granted requests, in bus order; its occupancy is the outstanding count
  ifu_fifo #(.W(AW), .DEPTH(DEPTH)) u_addr_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fire),
    .pop_i   (rsp),
    .flush_i (1'b0),
    .wdata_i (pc_q),
    .rdata_o (aq_head),
    .full_o  (aq_full),
    .empty_o (aq_empty),
    .count_o (aq_cnt)
  );

  assign ibus_req_o   = req;
  assign ibus_addr_o  = pc_q;
  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? NOP    : fifo_head.inst;
  assign inst_addr_o  = fifo_empty ? last_q : fifo_head.addr;
endmodule
